// File: rtl/dbg_bus_arb_pkg.sv
// rtl/dbg_bus_arb_pkg.sv - shared widths and FSM encodings for the debug bus arbiter
package dbg_bus_arb_pkg;

  localparam int RV32_ADDR_WIDTH = 32;
  localparam int RV32_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DBG_ARB_IDLE  = 2'd0,
    DBG_ARB_JREQ  = 2'd1,
    DBG_ARB_JRESP = 2'd2,
    DBG_ARB_JLOW  = 2'd3
  } dbg_arb_state_e;

endpackage

// File: rtl/dbg_req_capture.sv
// rtl/dbg_req_capture.sv - rising-edge detect on the DM request level and pending-request latch
module dbg_req_capture #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_accept,
  output logic              o_new_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data
);

  logic              r_vld_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_edge;

  // Edges are only taken while the arbiter is idle, so the pending fields stay stable mid-access.
  assign w_edge    = i_vld & ~r_vld_q;
  assign o_new_req = w_edge & i_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_q   <= 1'b0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_vld_q <= i_vld;
      if (o_new_req) begin
        r_addr    <= i_addr;
        r_wr_en   <= i_wr_en;
        r_wr_data <= i_wr_data;
      end
    end
  end

  assign o_addr    = r_addr;
  assign o_wr_en   = r_wr_en;
  assign o_wr_data = r_wr_data;

endmodule

// File: rtl/dbg_bus_arb.sv
// rtl/dbg_bus_arb.sv - two-master arbiter sharing the data-memory port between core LSU and JTAG DM
module dbg_bus_arb
  import dbg_bus_arb_pkg::*;
#(
  parameter int ADDR_W = RV32_ADDR_WIDTH,
  parameter int DATA_W = RV32_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_core_req,
  input  logic [ADDR_W-1:0]   i_core_addr,
  input  logic                i_core_wr_en,
  input  logic [DATA_W-1:0]   i_core_wr_data,
  input  logic [DATA_W/8-1:0] i_core_wr_strb,
  output logic                o_core_gnt,
  output logic                o_core_stall,
  output logic                o_core_rd_vld,
  output logic [DATA_W-1:0]   o_core_rd_data,
  input  logic                i_jtag_bus_vld,
  input  logic [ADDR_W-1:0]   i_jtag_mem_addr,
  input  logic                i_jtag_mem_wr_en,
  input  logic [DATA_W-1:0]   i_jtag_mem_wr_data,
  output logic [DATA_W-1:0]   o_jtag_mem_rd_data,
  output logic                o_jtag_bus_done,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_strb,
  input  logic                i_mem_rdy,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  dbg_arb_state_e    r_state, w_next_state;
  logic              w_new_req;
  logic [ADDR_W-1:0] w_pend_addr;
  logic              w_pend_we;
  logic [DATA_W-1:0] w_pend_wdata;
  logic              w_jtag_owns;
  logic              w_accept;
  logic              w_jtag_rd_ret;
  logic              r_owner_jtag;
  logic              r_rd_flag;
  logic [DATA_W-1:0] r_jtag_rd_data;

  dbg_req_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (i_jtag_bus_vld),
    .i_addr    (i_jtag_mem_addr),
    .i_wr_en   (i_jtag_mem_wr_en),
    .i_wr_data (i_jtag_mem_wr_data),
    .i_accept  (r_state == DBG_ARB_IDLE),
    .o_new_req (w_new_req),
    .o_addr    (w_pend_addr),
    .o_wr_en   (w_pend_we),
    .o_wr_data (w_pend_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DBG_ARB_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DBG_ARB_IDLE:  if (w_new_req) w_next_state = DBG_ARB_JREQ;
      DBG_ARB_JREQ:  if (i_mem_rdy) w_next_state = DBG_ARB_JRESP;
      DBG_ARB_JRESP: w_next_state = DBG_ARB_JLOW;
      DBG_ARB_JLOW:  if (!i_jtag_bus_vld) w_next_state = DBG_ARB_IDLE;
      default:       w_next_state = DBG_ARB_IDLE;
    endcase
  end

  always_comb begin
    w_jtag_owns     = (r_state == DBG_ARB_JREQ);
    o_jtag_bus_done = (r_state == DBG_ARB_JRESP);
    o_mem_req       = i_core_req;
    o_mem_we        = i_core_wr_en;
    o_mem_addr      = i_core_addr;
    o_mem_wdata     = i_core_wr_data;
    o_mem_strb      = i_core_wr_strb;
    if (w_jtag_owns) begin
      o_mem_req   = 1'b1;
      o_mem_we    = w_pend_we;
      o_mem_addr  = w_pend_addr;
      o_mem_wdata = w_pend_wdata;
      o_mem_strb  = '1;
    end
    o_core_gnt   = i_core_req & i_mem_rdy & ~w_jtag_owns;
    o_core_stall = i_core_req & ~o_core_gnt;
  end

  // Returning data is routed by who owned the port when the read was accepted, not by current state.
  assign w_accept      = o_mem_req & i_mem_rdy;
  assign w_jtag_rd_ret = r_rd_flag & r_owner_jtag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_jtag   <= 1'b0;
      r_rd_flag      <= 1'b0;
      r_jtag_rd_data <= '0;
    end else begin
      r_owner_jtag <= w_jtag_owns;
      r_rd_flag    <= w_accept & ~o_mem_we;
      if (w_jtag_rd_ret) r_jtag_rd_data <= i_mem_rdata;
    end
  end

  assign o_core_rd_vld      = r_rd_flag & ~r_owner_jtag;
  assign o_core_rd_data     = i_mem_rdata;
  assign o_jtag_mem_rd_data = w_jtag_rd_ret ? i_mem_rdata : r_jtag_rd_data;

endmodule
